// File: rtl/subr8s_pkg.sv
// subr8s_pkg: shared width, FSM state, counter width and error-count ceiling for subr8s_chk
package subr8s_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [7:0] ERR_MAX = 8'hFF;
endpackage

// File: rtl/subr8s_chk_fs1.sv
// fs1: 1-bit full subtractor computing o - a - borrow
// ports: i_o, i_a minuend/subtrahend bits; i_br borrow in; o_d difference bit; o_br borrow out
module fs1 (
    input  logic i_o,
    input  logic i_a,
    input  logic i_br,
    output logic o_d,
    output logic o_br
);
    assign o_d  = i_o ^ i_a ^ i_br;
    assign o_br = (~i_o & i_a) | (~(i_o ^ i_a) & i_br);
endmodule

// File: rtl/subr8s_chk.sv
// subr8s_chk: serial checker recovering B = O - sext(A) and flagging adder mismatches
// ports: in_valid/in_ready accept a, o, b_exp; out_valid/out_ready hand off b_rec, ovf, mismatch;
//        err_cnt counts mismatching handoffs and saturates at 0xFF
module subr8s_chk
    import subr8s_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W:0]   o,
    input  logic [W-1:0] b_exp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] b_rec,
    output logic         ovf,
    output logic         mismatch,
    output logic [7:0]   err_cnt
);
    localparam int CW = cnt_w(W);
    state_t        r_state;
    logic [W:0]    r_a;
    logic [W:0]    r_o;
    logic [W:0]    r_d;
    logic [W-1:0]  r_bexp;
    logic [W-1:0]  r_brec;
    logic [CW-1:0] r_cnt;
    logic          r_br;
    logic          r_ovf;
    logic          r_mis;
    logic [7:0]    r_err;
    logic          w_d;
    logic          w_br;
    logic [W:0]    w_dn;
    logic          w_ovf;
    fs1 u_fs1 (.i_o(r_o[0]), .i_a(r_a[0]), .i_br(r_br), .o_d(w_d), .o_br(w_br));
    // operands shift right each step; difference bits enter at the top so D is aligned after W+1 steps
    assign w_dn      = {w_d, r_d[W:1]};
    assign w_ovf     = w_dn[W] ^ w_dn[W-1];
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == HOLD;
    assign b_rec     = r_brec;
    assign ovf       = r_ovf;
    assign mismatch  = r_mis;
    assign err_cnt   = r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_o     <= '0;
            r_d     <= '0;
            r_bexp  <= '0;
            r_brec  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_ovf   <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_state <= SHIFT;
                    r_a     <= {a[W-1], a};
                    r_o     <= o;
                    r_bexp  <= b_exp;
                    r_d     <= '0;
                    r_cnt   <= '0;
                    r_br    <= 1'b0;
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_o   <= r_o >> 1;
                    r_d   <= w_dn;
                    r_br  <= w_br;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W)) begin
                        r_state <= HOLD;
                        r_brec  <= w_dn[W-1:0];
                        r_ovf   <= w_ovf;
                        r_mis   <= w_ovf | (w_dn[W-1:0] != r_bexp);
                    end
                end
                HOLD: if (out_ready) begin
                    r_state <= IDLE;
                    if (r_mis && r_err != ERR_MAX) r_err <= r_err + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/subr8s_chk.md
SUBR8S_CHK -- requirements
Module: subr8s_chk

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width (9-bit sums, W+1 serial steps).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, request carries a, o and b_exp.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have port a, input, W, signed operand A (two's complement).
REQ-007 The block SHALL have port o, input, W+1, signed adder result O = A+B under check.
REQ-008 The block SHALL have port b_exp, input, W, signed operand B the adder was given.
REQ-009 The block SHALL have port out_valid, output, 1, result fields valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port b_rec, output, W, recovered B = (O - sext(A))[W-1:0].
REQ-012 The block SHALL have port ovf, output, 1, O - sext(A) not representable in W bits.
REQ-013 The block SHALL have port mismatch, output, 1, ovf OR (b_rec != b_exp).
REQ-014 The block SHALL have port err_cnt, output, 8, saturating count of mismatching results handed off.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and HOLD; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-016 IDLE -> SHIFT SHALL occur on the edge where in_valid&&in_ready: latch a (sign-extended to W+1), o and b_exp; clear step counter and borrow.
REQ-017 In SHIFT, one difference bit per cycle SHALL be produced, LSB first, at step i: d_i = o_i ^ a_i ^ br; br' = (~o_i & a_i) | (~(o_i ^ a_i) & br).
REQ-018 SHIFT SHALL last exactly W+1 cycles; out_valid SHALL rise exactly W+1 edges after the accepting edge (9 for W=8).
REQ-019 With 9-bit difference D, b_rec SHALL be D[W-1:0], ovf SHALL be D[W] != D[W-1], and the final borrow SHALL be discarded.
REQ-020 In HOLD, b_rec, ovf and mismatch SHALL stay stable until out_valid&&out_ready, then the block SHALL return to IDLE.
REQ-021 No same-cycle re-accept: in_ready SHALL be 0 on the handoff edge and 1 on the following cycle.
REQ-022 err_cnt SHALL increment by 1 on each handoff with mismatch=1, SHALL saturate at 0xFF, and SHALL NOT wrap.
REQ-023 in_valid and input data SHALL be ignored outside IDLE.
REQ-024 b_rec, ovf and mismatch SHALL NOT be updated during SHIFT.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, in_ready=1, out_valid=0, b_rec=0, ovf=0, mismatch=0, err_cnt=0, and counter and borrow cleared.
REQ-026 Reset during SHIFT or HOLD SHALL abandon the operation with no handoff and no err_cnt change.
REQ-027 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 Shared package subr8s_pkg SHALL hold W, the state enum (IDLE/SHIFT/HOLD), the counter width and the err_cnt saturation value.
REQ-029 One sub-module, fs1 (combinational 1-bit full subtractor: o_i, a_i, br_in -> d_i, br_out), SHALL be instantiated once and reused every SHIFT cycle.

Verification
REQ-030 The bench SHALL apply a=0x05, o=0x00C, b_exp=0x07 and check out_valid 9 edges later with b_rec=0x07, ovf=0, mismatch=0, err_cnt=0.
REQ-031 The bench SHALL apply a=0x80, o=0x100, b_exp=0x80 (-128 + -128) and check b_rec=0x80, ovf=0, mismatch=0.
REQ-032 The bench SHALL apply a=0x80, o=0x07F (D=255), b_exp=0x7F and check ovf=1, mismatch=1, and err_cnt=1 after handoff.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in HOLD and check outputs stable, in_ready=0 and a new in_valid ignored; after out_ready=1, check IDLE the next cycle.
REQ-034 The bench SHALL apply 256 consecutive requests with a=0x01, o=0x001, b_exp=0x01 and check err_cnt=0xFF after the last (saturated).
REQ-035 The bench SHALL assert rst at step 4 of SHIFT and check out_valid=0, err_cnt=0, in_ready=1 immediately, and that the next request completes correctly.
